// File: rtl/cp0_exc_regfile.sv
// CP0 register file: commits exception_type codes from MEM, services MTC0/MFC0 and runs Count/Compare.
// Optional timer interrupt (Cause.TI / IP7) enabled by defining CP0_TIMER_INT_EN.
module cp0_exc_regfile #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int unsigned HW_INT_W   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         exception_type,
    input  logic [31:0]         mem_pc,
    input  logic                mem_in_delayslot,
    input  logic [31:0]         mem_bad_addr,
    input  logic                we,
    input  logic [4:0]          waddr,
    input  logic [31:0]         wdata,
    input  logic [4:0]          raddr,
    output logic [31:0]         rdata,
    input  logic [HW_INT_W-1:0] hw_int,
    output logic [31:0]         CP0_status,
    output logic [31:0]         CP0_cause,
    output logic [31:0]         CP0_epc,
    output logic                flush,
    output logic [31:0]         redirect_pc
);

    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL    = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES    = 32'h0000_0005;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_BREAK   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI      = 32'h0000_000A;
    localparam logic [31:0] EXC_OVF     = 32'h0000_000C;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000E;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_count_tog;
    logic        r_flush;
    logic [31:0] r_redirect_pc;

    logic        w_is_exc;
    logic        w_is_eret;
    logic        w_is_addr_err;
    logic        w_mtc0;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic        w_ti_next;
    logic [31:0] w_count_next;
    logic [31:0] w_status_next;
    logic [31:0] w_cause_next;
    logic [31:0] w_epc_next;

    always_comb begin
        w_is_exc = 1'b0;
        case (exception_type)
            EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYSCALL,
            EXC_BREAK, EXC_RI, EXC_OVF: w_is_exc = 1'b1;
            default:                    w_is_exc = 1'b0;
        endcase
    end

    assign w_is_eret     = (exception_type == EXC_ERET);
    assign w_is_addr_err = (exception_type == EXC_ADEL) || (exception_type == EXC_ADES);

    // The MTC0 sitting in MEM alongside an exception/ERET is flushed, so its write is dropped.
    assign w_mtc0       = we && !w_is_exc && !w_is_eret;
    assign w_wr_count   = w_mtc0 && (waddr == REG_COUNT);
    assign w_wr_compare = w_mtc0 && (waddr == REG_COMPARE);
    assign w_wr_status  = w_mtc0 && (waddr == REG_STATUS);
    assign w_wr_cause   = w_mtc0 && (waddr == REG_CAUSE);
    assign w_wr_epc     = w_mtc0 && (waddr == REG_EPC);

    assign w_count_next = w_wr_count  ? wdata :
                          r_count_tog ? r_count + 32'd1 : r_count;

`ifdef CP0_TIMER_INT_EN
    logic w_timer_hit;
    // Only a real increment can produce a match, so Count==Compare==0 out of reset stays quiet.
    assign w_timer_hit = !w_wr_count && r_count_tog && (w_count_next == r_compare);
    assign w_ti_next   = !w_wr_compare && (r_cause[30] || w_timer_hit);
`else
    assign w_ti_next   = 1'b0;
`endif

    always_comb begin
        w_status_next = r_status;
        if (w_wr_status) begin
            w_status_next = (r_status & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
        end
        if (w_is_exc) begin
            w_status_next[1] = 1'b1;
        end else if (w_is_eret) begin
            w_status_next[1] = 1'b0;
        end
    end

    always_comb begin
        w_cause_next        = '0;
        w_cause_next[31]    = (w_is_exc && !r_status[1]) ? mem_in_delayslot : r_cause[31];
        w_cause_next[30]    = w_ti_next;
        w_cause_next[15:10] = {w_ti_next | hw_int[5], hw_int[4:0]};
        w_cause_next[9:8]   = w_wr_cause ? wdata[9:8] : r_cause[9:8];
        if (w_is_exc) begin
            w_cause_next[6:2] = (exception_type == EXC_INT) ? 5'd0 : exception_type[4:0];
        end else begin
            w_cause_next[6:2] = r_cause[6:2];
        end
    end

    always_comb begin
        w_epc_next = r_epc;
        if (w_is_exc && !r_status[1]) begin
            w_epc_next = mem_in_delayslot ? mem_pc - 32'd4 : mem_pc;
        end else if (w_wr_epc) begin
            w_epc_next = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status      <= STATUS_RESET;
            r_cause       <= '0;
            r_epc         <= '0;
            r_badvaddr    <= '0;
            r_count       <= '0;
            r_compare     <= '0;
            r_count_tog   <= 1'b0;
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_status    <= w_status_next;
            r_cause     <= w_cause_next;
            r_epc       <= w_epc_next;
            r_count     <= w_count_next;
            r_count_tog <= ~r_count_tog;
            if (w_wr_compare) begin
                r_compare <= wdata;
            end
            if (w_is_exc && w_is_addr_err) begin
                r_badvaddr <= mem_bad_addr;
            end
            r_flush <= w_is_exc || w_is_eret;
            if (w_is_exc) begin
                r_redirect_pc <= EXC_VECTOR;
            end else if (w_is_eret) begin
                r_redirect_pc <= r_epc;
            end
        end
    end

    always_comb begin
        case (raddr)
            REG_BADVADDR: rdata = r_badvaddr;
            REG_COUNT:    rdata = r_count;
            REG_COMPARE:  rdata = r_compare;
            REG_STATUS:   rdata = r_status;
            REG_CAUSE:    rdata = r_cause;
            REG_EPC:      rdata = r_epc;
            default:      rdata = '0;
        endcase
    end

    assign CP0_status  = r_status;
    assign CP0_cause   = r_cause;
    assign CP0_epc     = r_epc;
    assign flush       = r_flush;
    assign redirect_pc = r_redirect_pc;

endmodule
